reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Write side of the dual-issue 32x64 integer register file.
- Accepts paired (way0/way1) results from the execute stage through a valid/ready handshake and buffers them in a small in-order commit queue.
- Drives the register file's two write ports with registered outputs.
- Maintains the pending-write scoreboard that issue/decode consults before reading operands.

Parameters:
- XLEN, 64, data width of a register.
- DEPTH, 4, commit-queue entries (power of two, >=2); each entry holds one way0/way1 result pair.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- wb_valid_i  in  1  result pair valid.
- wb_ready_o  out  1  queue can accept a pair.
- way0_rdWriteEnable_i  in  1  way0 result writes rd.
- way0_rdAddr_i  in  5  way0 destination.
- way0_rdData_i  in  XLEN  way0 result.
- way1_rdWriteEnable_i  in  1  way1 result writes rd.
- way1_rdAddr_i  in  5  way1 destination.
- way1_rdData_i  in  XLEN  way1 result.
- rfWriteHold_i  in  1  debug halt; freezes draining.
- flush_i  in  1  pipeline flush.
- way0_reserve_i  in  1  issue reserves way0_resAddr_i.
- way0_resAddr_i  in  5  reserved destination, way0.
- way1_reserve_i  in  1  issue reserves way1_resAddr_i.
- way1_resAddr_i  in  5  reserved destination, way1.
- way0_rdWriteEnable_o  out  1  RF write port 0 enable.
- way0_rdAddr_o  out  5  RF write port 0 address.
- way0_rdData_o  out  XLEN  RF write port 0 data.
- way1_rdWriteEnable_o  out  1  RF write port 1 enable.
- way1_rdAddr_o  out  5  RF write port 1 address.
- way1_rdData_o  out  XLEN  RF write port 1 data.
- rdBusy_o  out  32  scoreboard; bit i = write to xi pending.
- reserveErr_o  out  1  sticky: reserve hit an already-busy register.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-low on reset_n.
- Reset: queue empty; wb_ready_o=1; all *_o write enables 0; addr and data outputs 0; rdBusy_o=0; reserveErr_o=0.
- Accept: a pair is pushed when wb_valid_i && wb_ready_o. wb_ready_o = !full, registered; it does not depend on the same-cycle pop.
- Drain: one pair is popped per cycle when the queue is not empty, !rfWriteHold_i and !flush_i.
- Write-port outputs are registered: a pair pushed into an empty queue at cycle N appears on the write ports at N+1 (bypass around the queue storage), and enables drop to 0 in any cycle nothing is popped. Throughput is 1 pair/cycle.
- Simultaneous push and pop when full: the push is not allowed (ready is already 0). When empty: pass-through as above.
- x0 rule: a write enable to rd=0 is forced to 0 on output; reservations of x0 are ignored. rdBusy_o[0] is always 0.
- Same-rd collision within a pair (both enables set, equal rd != 0): way1 is younger and wins; way0_rdWriteEnable_o=0 for that pair.
- Scoreboard update:
  - Set on reserve: bit = 1 for each asserted way*_reserve_i.
  - Clear on pop: bit = 0 for each rd actually written on the output.
  - Same cycle, same register, set and clear: set wins.
  - Reserving a bit that is already 1 (and not being cleared that cycle) sets reserveErr_o. reserveErr_o stays set until reset.
- Flush: in the flush cycle, the queue is emptied, no pop occurs (output enables 0 next cycle), and rdBusy_o is cleared to 0. Reserves asserted in the same cycle as flush_i are dropped. A push asserted with flush_i is discarded.
- rfWriteHold_i: the queue holds and the output enables are 0. Pushes continue until full. Scoreboard bits stay set.
- Reset mid-operation: queue contents are discarded without writing; all state returns to reset values next edge.
- Queue pointers are log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty; pointers wrap modulo 2*DEPTH.

Decomposition:
- Shared package rv_pkg: XLEN, REG_NUM=32, REG_ADDR_W=5, and the wb_pair_t struct {we0, rd0, data0, we1, rd1, data1}.
- One sub-module: wb_pair_fifo (DEPTH-entry synchronous FIFO of wb_pair_t, with push/pop/full/empty and a flush input). The scoreboard and collision/x0 logic stay in reg_writeback.

Test Plan:
- Reset, then push a single pair way0 x5=0x11, way1 x6=0x22 -> next cycle both write ports fire with those values; rdBusy_o bits 5 and 6 (reserved at issue) clear that cycle.
- Pair with both enables to rd=7 (0xAA on way0, 0xBB on way1) -> only way1 writes x7=0xBB; way0 enable is 0.
- Hold rfWriteHold_i and push 5 pairs with DEPTH=4 -> wb_ready_o=0 after 4 pushes and no writes occur. Release hold -> 4 consecutive write cycles in push order, then ready returns to 1.
- Reserve x9 and in the same cycle pop a write to x9 -> rdBusy_o[9] stays 1. Reserve x9 again while it is busy -> reserveErr_o=1.
- Queue with 3 pairs, assert flush_i -> queue empty, rdBusy_o=0, no write enables in the following cycle, wb_ready_o=1.
- Write or reserve x0 with data 0xFFFF -> no write enable on output; rdBusy_o[0]=0 throughout.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared register-file types: widths and the paired writeback result carried through the commit queue.
package rv_pkg;
  localparam int XLEN       = 64;
  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic                  we0;
    logic [REG_ADDR_W-1:0] rd0;
    logic [XLEN-1:0]       data0;
    logic                  we1;
    logic [REG_ADDR_W-1:0] rd1;
    logic [XLEN-1:0]       data1;
  } wb_pair_t;
endpackage

// File: rtl/wb_pair_fifo.sv
// In-order queue of writeback pairs with empty-queue bypass: a push into an empty queue pops the same cycle.
// full/empty come straight from the pointer flops; flush drops all entries.
module wb_pair_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     flush,
  input  logic     push,
  input  wb_pair_t push_data,
  input  logic     pop,
  output logic     pop_vld,
  output wb_pair_t pop_data,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);

  wb_pair_t      mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          bypass;
  logic          store;
  logic          adv_rd;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bypass   = empty && push;
  assign pop_vld  = pop && (!empty || push);
  assign pop_data = empty ? push_data : mem[rd_ptr[AW-1:0]];
  // A bypassed pair goes straight to the output and never occupies a slot.
  assign store    = push && !full && !(bypass && pop);
  assign adv_rd   = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (store)  wr_ptr <= wr_ptr + 1'b1;
      if (adv_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/reg_writeback.sv
// Register-file write side: queues execute result pairs, drives both RF write ports one cycle after pop,
// and tracks pending writes for issue. wb_ready_o drops only when the queue is full.
module reg_writeback #(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wb_valid_i,
  output logic            wb_ready_o,
  input  logic            way0_rdWriteEnable_i,
  input  logic [4:0]      way0_rdAddr_i,
  input  logic [XLEN-1:0] way0_rdData_i,
  input  logic            way1_rdWriteEnable_i,
  input  logic [4:0]      way1_rdAddr_i,
  input  logic [XLEN-1:0] way1_rdData_i,
  input  logic            rfWriteHold_i,
  input  logic            flush_i,
  input  logic            way0_reserve_i,
  input  logic [4:0]      way0_resAddr_i,
  input  logic            way1_reserve_i,
  input  logic [4:0]      way1_resAddr_i,
  output logic            way0_rdWriteEnable_o,
  output logic [4:0]      way0_rdAddr_o,
  output logic [XLEN-1:0] way0_rdData_o,
  output logic            way1_rdWriteEnable_o,
  output logic [4:0]      way1_rdAddr_o,
  output logic [XLEN-1:0] way1_rdData_o,
  output logic [31:0]     rdBusy_o,
  output logic            reserveErr_o
);
  import rv_pkg::*;

  wb_pair_t          in_pair;
  wb_pair_t          pd;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop_req;
  logic              pop_vld;
  logic              we0_eff;
  logic              we1_eff;
  logic [REG_NUM-1:0] clr_mask;
  logic [REG_NUM-1:0] set_mask;
  logic [REG_NUM-1:0] busy_q;
  logic              err_q;

  assign in_pair    = '{we0: way0_rdWriteEnable_i, rd0: way0_rdAddr_i, data0: way0_rdData_i,
                        we1: way1_rdWriteEnable_i, rd1: way1_rdAddr_i, data1: way1_rdData_i};
  assign wb_ready_o = !full;
  assign push       = wb_valid_i && !full && !flush_i;
  assign pop_req    = !rfWriteHold_i && !flush_i;

  wb_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush_i),
    .push      (push),
    .push_data (in_pair),
    .pop       (pop_req),
    .pop_vld   (pop_vld),
    .pop_data  (pd),
    .full      (full),
    .empty     (empty)
  );

  // x0 is never written; on a same-rd pair the younger way1 wins.
  assign we1_eff = pd.we1 && (pd.rd1 != '0);
  assign we0_eff = pd.we0 && (pd.rd0 != '0) && !(we1_eff && (pd.rd1 == pd.rd0));

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (pop_vld && we0_eff) clr_mask[pd.rd0] = 1'b1;
    if (pop_vld && we1_eff) clr_mask[pd.rd1] = 1'b1;
    if (!flush_i && way0_reserve_i && (way0_resAddr_i != '0)) set_mask[way0_resAddr_i] = 1'b1;
    if (!flush_i && way1_reserve_i && (way1_resAddr_i != '0)) set_mask[way1_resAddr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q               <= '0;
      err_q                <= 1'b0;
      way0_rdWriteEnable_o <= 1'b0;
      way0_rdAddr_o        <= '0;
      way0_rdData_o        <= '0;
      way1_rdWriteEnable_o <= 1'b0;
      way1_rdAddr_o        <= '0;
      way1_rdData_o        <= '0;
    end else begin
      busy_q <= flush_i ? '0 : ((busy_q & ~clr_mask) | set_mask);
      if (|(set_mask & busy_q & ~clr_mask)) err_q <= 1'b1;
      way0_rdWriteEnable_o <= pop_vld && we0_eff;
      way1_rdWriteEnable_o <= pop_vld && we1_eff;
      if (pop_vld) begin
        way0_rdAddr_o <= pd.rd0;
        way0_rdData_o <= pd.data0;
        way1_rdAddr_o <= pd.rd1;
        way1_rdData_o <= pd.data1;
      end
    end
  end

  assign rdBusy_o     = busy_q;
  assign reserveErr_o = err_q;
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: each task drives one scenario and checks outputs 1ns after the clock edge.
module tb_reg_writeback;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_valid_i;
  logic        wb_ready_o;
  logic        way0_rdWriteEnable_i;
  logic [4:0]  way0_rdAddr_i;
  logic [63:0] way0_rdData_i;
  logic        way1_rdWriteEnable_i;
  logic [4:0]  way1_rdAddr_i;
  logic [63:0] way1_rdData_i;
  logic        rfWriteHold_i;
  logic        flush_i;
  logic        way0_reserve_i;
  logic [4:0]  way0_resAddr_i;
  logic        way1_reserve_i;
  logic [4:0]  way1_resAddr_i;
  logic        way0_rdWriteEnable_o;
  logic [4:0]  way0_rdAddr_o;
  logic [63:0] way0_rdData_o;
  logic        way1_rdWriteEnable_o;
  logic [4:0]  way1_rdAddr_o;
  logic [63:0] way1_rdData_o;
  logic [31:0] rdBusy_o;
  logic        reserveErr_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_writeback dut (
    .clk(clk), .reset_n(reset_n), .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
    .way0_rdWriteEnable_i(way0_rdWriteEnable_i), .way0_rdAddr_i(way0_rdAddr_i), .way0_rdData_i(way0_rdData_i),
    .way1_rdWriteEnable_i(way1_rdWriteEnable_i), .way1_rdAddr_i(way1_rdAddr_i), .way1_rdData_i(way1_rdData_i),
    .rfWriteHold_i(rfWriteHold_i), .flush_i(flush_i),
    .way0_reserve_i(way0_reserve_i), .way0_resAddr_i(way0_resAddr_i),
    .way1_reserve_i(way1_reserve_i), .way1_resAddr_i(way1_resAddr_i),
    .way0_rdWriteEnable_o(way0_rdWriteEnable_o), .way0_rdAddr_o(way0_rdAddr_o), .way0_rdData_o(way0_rdData_o),
    .way1_rdWriteEnable_o(way1_rdWriteEnable_o), .way1_rdAddr_o(way1_rdAddr_o), .way1_rdData_o(way1_rdData_o),
    .rdBusy_o(rdBusy_o), .reserveErr_o(reserveErr_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    wb_valid_i = 0; way0_rdWriteEnable_i = 0; way0_rdAddr_i = 0; way0_rdData_i = 0;
    way1_rdWriteEnable_i = 0; way1_rdAddr_i = 0; way1_rdData_i = 0; flush_i = 0;
    way0_reserve_i = 0; way0_resAddr_i = 0; way1_reserve_i = 0; way1_resAddr_i = 0;
  endtask

  task automatic set_pair(input logic we0, input logic [4:0] rd0, input logic [63:0] d0,
                          input logic we1, input logic [4:0] rd1, input logic [63:0] d1);
    wb_valid_i = 1;
    way0_rdWriteEnable_i = we0; way0_rdAddr_i = rd0; way0_rdData_i = d0;
    way1_rdWriteEnable_i = we1; way1_rdAddr_i = rd1; way1_rdData_i = d1;
  endtask

  task automatic test_reset();
    reset_n = 0; rfWriteHold_i = 0; clr_in();
    step(); step();
    checks++; if (wb_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", wb_ready_o); end
    checks++; if ({way0_rdWriteEnable_o, way1_rdWriteEnable_o} !== 2'b00) begin failures++; $display("FAIL reset_we got=%b exp=00", {way0_rdWriteEnable_o, way1_rdWriteEnable_o}); end
    checks++; if ({way0_rdAddr_o, way1_rdAddr_o, way0_rdData_o, way1_rdData_o} !== '0) begin failures++; $display("FAIL reset_addr_data got=%h exp=0", {way0_rdAddr_o, way1_rdAddr_o, way0_rdData_o, way1_rdData_o}); end
    checks++; if (rdBusy_o !== 32'h0 || reserveErr_o !== 1'b0) begin failures++; $display("FAIL reset_sb busy=%h err=%0b exp=0/0", rdBusy_o, reserveErr_o); end
    reset_n = 1;
  endtask

  task automatic test_single();
    way0_reserve_i = 1; way0_resAddr_i = 5; way1_reserve_i = 1; way1_resAddr_i = 6;
    step(); clr_in();
    checks++; if (rdBusy_o !== 32'h0000_0060) begin failures++; $display("FAIL single_reserve busy=%h exp=00000060", rdBusy_o); end
    set_pair(1, 5, 64'h11, 1, 6, 64'h22);
    step(); clr_in();
    checks++; if (way0_rdWriteEnable_o !== 1 || way0_rdAddr_o !== 5 || way0_rdData_o !== 64'h11) begin failures++; $display("FAIL single_way0 we=%0b rd=%0d d=%h exp=1/5/11", way0_rdWriteEnable_o, way0_rdAddr_o, way0_rdData_o); end
    checks++; if (way1_rdWriteEnable_o !== 1 || way1_rdAddr_o !== 6 || way1_rdData_o !== 64'h22) begin failures++; $display("FAIL single_way1 we=%0b rd=%0d d=%h exp=1/6/22", way1_rdWriteEnable_o, way1_rdAddr_o, way1_rdData_o); end
    checks++; if (rdBusy_o !== 32'h0) begin failures++; $display("FAIL single_clear busy=%h exp=0", rdBusy_o); end
    step();
    checks++; if ({way0_rdWriteEnable_o, way1_rdWriteEnable_o} !== 2'b00) begin failures++; $display("FAIL single_idle we=%b exp=00", {way0_rdWriteEnable_o, way1_rdWriteEnable_o}); end
  endtask

  task automatic test_collision();
    set_pair(1, 7, 64'hAA, 1, 7, 64'hBB);
    step(); clr_in();
    checks++; if (way0_rdWriteEnable_o !== 1'b0) begin failures++; $display("FAIL coll_way0 we=%0b exp=0", way0_rdWriteEnable_o); end
    checks++; if (way1_rdWriteEnable_o !== 1 || way1_rdAddr_o !== 7 || way1_rdData_o !== 64'hBB) begin failures++; $display("FAIL coll_way1 we=%0b rd=%0d d=%h exp=1/7/bb", way1_rdWriteEnable_o, way1_rdAddr_o, way1_rdData_o); end
  endtask

  task automatic test_hold();
    rfWriteHold_i = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (wb_ready_o !== 1'b1) begin failures++; $display("FAIL hold_ready_%0d got=%0b exp=1", i, wb_ready_o); end
      set_pair(1, 5'(10 + i), 64'(100 + i), 0, 0, 0);
      step(); clr_in();
      checks++; if ({way0_rdWriteEnable_o, way1_rdWriteEnable_o} !== 2'b00) begin failures++; $display("FAIL hold_nowrite_%0d we=%b exp=00", i, {way0_rdWriteEnable_o, way1_rdWriteEnable_o}); end
    end
    checks++; if (wb_ready_o !== 1'b0) begin failures++; $display("FAIL hold_full got=%0b exp=0", wb_ready_o); end
    set_pair(1, 14, 64'h999, 0, 0, 0);
    step(); clr_in();
    checks++; if (wb_ready_o !== 1'b0 || way0_rdWriteEnable_o !== 1'b0) begin failures++; $display("FAIL hold_fifth ready=%0b we=%0b exp=0/0", wb_ready_o, way0_rdWriteEnable_o); end
    rfWriteHold_i = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (way0_rdWriteEnable_o !== 1 || way0_rdAddr_o !== 5'(10 + i) || way0_rdData_o !== 64'(100 + i)) begin failures++; $display("FAIL drain_%0d we=%0b rd=%0d d=%0d exp=1/%0d/%0d", i, way0_rdWriteEnable_o, way0_rdAddr_o, way0_rdData_o, 10 + i, 100 + i); end
    end
    step();
    checks++; if (wb_ready_o !== 1'b1 || way0_rdWriteEnable_o !== 1'b0) begin failures++; $display("FAIL drain_done ready=%0b we=%0b exp=1/0", wb_ready_o, way0_rdWriteEnable_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      set_pair(1, 5'(16 + i), 64'(200 + i), 1, 5'(26 + i), 64'(300 + i));
      step();
      checks++; if (way0_rdWriteEnable_o !== 1 || way0_rdAddr_o !== 5'(16 + i) || way1_rdData_o !== 64'(300 + i)) begin failures++; $display("FAIL b2b_%0d we=%0b rd0=%0d d1=%0d exp=1/%0d/%0d", i, way0_rdWriteEnable_o, way0_rdAddr_o, way1_rdData_o, 16 + i, 300 + i); end
    end
    clr_in(); step();
  endtask

  task automatic test_reserve_pop();
    way0_reserve_i = 1; way0_resAddr_i = 9;
    step(); clr_in();
    checks++; if (rdBusy_o[9] !== 1'b1 || reserveErr_o !== 1'b0) begin failures++; $display("FAIL res9 busy9=%0b err=%0b exp=1/0", rdBusy_o[9], reserveErr_o); end
    set_pair(1, 9, 64'h99, 0, 0, 0);
    way0_reserve_i = 1; way0_resAddr_i = 9;
    step(); clr_in();
    checks++; if (way0_rdWriteEnable_o !== 1 || way0_rdAddr_o !== 9) begin failures++; $display("FAIL res_pop_write we=%0b rd=%0d exp=1/9", way0_rdWriteEnable_o, way0_rdAddr_o); end
    checks++; if (rdBusy_o[9] !== 1'b1 || reserveErr_o !== 1'b0) begin failures++; $display("FAIL res_pop_setwins busy9=%0b err=%0b exp=1/0", rdBusy_o[9], reserveErr_o); end
    way1_reserve_i = 1; way1_resAddr_i = 9;
    step(); clr_in();
    checks++; if (reserveErr_o !== 1'b1) begin failures++; $display("FAIL res_err got=%0b exp=1", reserveErr_o); end
    step();
    checks++; if (reserveErr_o !== 1'b1) begin failures++; $display("FAIL res_err_sticky got=%0b exp=1", reserveErr_o); end
  endtask

  task automatic test_flush();
    way0_reserve_i = 1; way0_resAddr_i = 20;
    step(); clr_in();
    rfWriteHold_i = 1;
    for (int i = 0; i < 3; i++) begin
      set_pair(1, 5'(21 + i), 64'(i), 0, 0, 0);
      step(); clr_in();
    end
    set_pair(1, 24, 64'h5, 0, 0, 0);
    way1_reserve_i = 1; way1_resAddr_i = 24; flush_i = 1;
    step(); clr_in();
    checks++; if (rdBusy_o !== 32'h0) begin failures++; $display("FAIL flush_busy got=%h exp=0", rdBusy_o); end
    checks++; if (wb_ready_o !== 1'b1 || way0_rdWriteEnable_o !== 1'b0) begin failures++; $display("FAIL flush_state ready=%0b we=%0b exp=1/0", wb_ready_o, way0_rdWriteEnable_o); end
    rfWriteHold_i = 0;
    step(); step();
    checks++; if (way0_rdWriteEnable_o !== 1'b0 || rdBusy_o !== 32'h0) begin failures++; $display("FAIL flush_empty we=%0b busy=%h exp=0/0", way0_rdWriteEnable_o, rdBusy_o); end
  endtask

  task automatic test_x0();
    set_pair(1, 0, 64'hFFFF, 1, 0, 64'hFFFF);
    way0_reserve_i = 1; way0_resAddr_i = 0; way1_reserve_i = 1; way1_resAddr_i = 0;
    step(); clr_in();
    checks++; if ({way0_rdWriteEnable_o, way1_rdWriteEnable_o} !== 2'b00) begin failures++; $display("FAIL x0_we got=%b exp=00", {way0_rdWriteEnable_o, way1_rdWriteEnable_o}); end
    checks++; if (rdBusy_o[0] !== 1'b0) begin failures++; $display("FAIL x0_busy got=%0b exp=0", rdBusy_o[0]); end
  endtask

  task automatic test_reset_mid();
    rfWriteHold_i = 1;
    set_pair(1, 3, 64'h33, 0, 0, 0);
    way0_reserve_i = 1; way0_resAddr_i = 15;
    step(); clr_in();
    set_pair(1, 4, 64'h44, 0, 0, 0);
    step(); clr_in();
    reset_n = 0;
    step();
    checks++; if (rdBusy_o !== 32'h0 || reserveErr_o !== 1'b0 || wb_ready_o !== 1'b1) begin failures++; $display("FAIL midreset busy=%h err=%0b ready=%0b exp=0/0/1", rdBusy_o, reserveErr_o, wb_ready_o); end
    reset_n = 1; rfWriteHold_i = 0;
    step(); step();
    checks++; if (way0_rdWriteEnable_o !== 1'b0) begin failures++; $display("FAIL midreset_discard we=%0b exp=0", way0_rdWriteEnable_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_collision();
    test_hold();
    test_back_to_back();
    test_reserve_pop();
    test_flush();
    test_x0();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
